// File: rtl/qspi_rr_collector.sv
// Round-robin collector: grabs whole packets from NUM_CH channels and streams them LANE_W bits per beat.
// Optional COLLECTOR_HEADER_EN prefixes each packet with a one-beat channel-index header.
module qspi_rr_collector #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned PKT_W  = 128,
    parameter int unsigned LANE_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*PKT_W-1:0]  ch_data,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        ch_capture,
    output logic [LANE_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy
);

    localparam int unsigned BEATS = PKT_W / LANE_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CH - 1);
    localparam logic             SINGLE_BEAT = (BEATS == 1);

`ifdef COLLECTOR_HEADER_EN
    typedef enum logic [1:0] {IDLE, SEND, HDR} state_t;
`else
    typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   beat_cnt;
    logic [PKT_W-1:0]   packet_q;

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PKT_W-1:0]   grant_pkt;
    int unsigned        cand;
    logic [CNT_W-1:0]   next_cnt;

    // Search starts at rr_ptr so the most recently served channel has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = (32'(rr_ptr) + i) % NUM_CH;
            if (!grant_found && ch_valid[PTR_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        grant_pkt = ch_data[grant_idx*PKT_W +: PKT_W];
        next_cnt  = beat_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            packet_q   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            ch_capture <= '0;
            busy       <= 1'b0;
        end else begin
            ch_capture <= '0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        packet_q   <= grant_pkt;
                        ch_capture <= NUM_CH'(1) << grant_idx;
                        rr_ptr     <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
                        beat_cnt   <= '0;
                        out_valid  <= 1'b1;
                        busy       <= 1'b1;
`ifdef COLLECTOR_HEADER_EN
                        state      <= HDR;
                        out_data   <= LANE_W'(grant_idx);
                        out_last   <= 1'b0;
`else
                        state      <= SEND;
                        out_data   <= grant_pkt[LANE_W-1:0];
                        out_last   <= SINGLE_BEAT;
`endif
                    end
                end
`ifdef COLLECTOR_HEADER_EN
                HDR: begin
                    if (out_ready) begin
                        state    <= SEND;
                        beat_cnt <= '0;
                        out_data <= packet_q[LANE_W-1:0];
                        out_last <= SINGLE_BEAT;
                    end
                end
`endif
                SEND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            beat_cnt <= next_cnt;
                            out_data <= packet_q[next_cnt*LANE_W +: LANE_W];
                            out_last <= (next_cnt == LAST_CNT);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_rr_collector.sv
// Directed bench for qspi_rr_collector at NUM_CH=4, PKT_W=16, LANE_W=4; follows COLLECTOR_HEADER_EN if defined.
`timescale 1ns/1ps
module tb_qspi_rr_collector;

    localparam int NUM_CH = 4;
    localparam int PKT_W  = 16;
    localparam int LANE_W = 4;

    logic                    clk;
    logic                    reset;
    logic [NUM_CH*PKT_W-1:0] ch_data;
    logic [NUM_CH-1:0]       ch_valid;
    logic [NUM_CH-1:0]       ch_capture;
    logic [LANE_W-1:0]       out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic                    busy;

    int checks = 0;
    int passes = 0;
    logic [3:0]  exp_q[$];
    logic [15:0] pkts [4];

    qspi_rr_collector #(.NUM_CH(NUM_CH), .PKT_W(PKT_W), .LANE_W(LANE_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .ch_capture (ch_capture),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    // Expected beat list: optional header (channel index) then payload nibbles LSB first.
    task automatic load_expect(input int ch, input logic [15:0] pkt);
        exp_q.delete();
`ifdef COLLECTOR_HEADER_EN
        exp_q.push_back(4'(ch));
`endif
        for (int i = 0; i < 4; i++) exp_q.push_back(pkt[i*4 +: 4]);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_last !== 1'b0 || ch_capture !== 4'h0 || busy !== 1'b0)
            $display("FAIL reset_state: valid=%b data=%h last=%b cap=%b busy=%b want all 0",
                     out_valid, out_data, out_last, ch_capture, busy);
        else passes++;
        reset = 1'b0;
        @(negedge clk);
        ch_data[0 +: 16] = 16'h5A5A;
        ch_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || ch_capture !== 4'b0001)
            $display("FAIL reset_pre_grant: valid=%b cap=%b want valid=1 cap=0001", out_valid, ch_capture);
        else passes++;
        ch_valid = 4'b0000;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_last !== 1'b0 || ch_capture !== 4'h0 || busy !== 1'b0)
            $display("FAIL reset_async: valid=%b data=%h last=%b cap=%b busy=%b want all 0",
                     out_valid, out_data, out_last, ch_capture, busy);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || ch_capture !== 4'h0)
                $display("FAIL reset_idle cyc%0d: valid=%b cap=%b want valid=0 cap=0000", c, out_valid, ch_capture);
            else passes++;
        end
    endtask

    task automatic test_single_packet();
        int n;
        load_expect(2, 16'hA5C3);
        n = exp_q.size();
        @(negedge clk);
        ch_data = '0;
        ch_data[2*16 +: 16] = 16'hA5C3;
        ch_valid = 4'b0100;
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) ch_valid = 4'b0000;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[k] || out_last !== (k == n - 1))
                $display("FAIL single_beat%0d: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                         k, out_valid, out_data, out_last, exp_q[k], (k == n - 1));
            else passes++;
            checks++;
            if (ch_capture !== ((k == 0) ? 4'b0100 : 4'b0000) || busy !== 1'b1)
                $display("FAIL single_cap%0d: cap=%b busy=%b want cap=%b busy=1",
                         k, ch_capture, busy, ((k == 0) ? 4'b0100 : 4'b0000));
            else passes++;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ch_capture !== 4'h0)
            $display("FAIL single_idle: valid=%b busy=%b cap=%b want 0 0 0000", out_valid, busy, ch_capture);
        else passes++;
    endtask

    task automatic test_backpressure();
        int n, k, stall, cyc, stall_at;
`ifdef COLLECTOR_HEADER_EN
        stall_at = 2;
`else
        stall_at = 1;
`endif
        load_expect(2, 16'hA5C3);
        n = exp_q.size();
        k = 0; stall = 0; cyc = 0;
        @(negedge clk);
        ch_valid = 4'b0100;
        out_ready = 1'b1;
        while (k < n && cyc < 40) begin
            @(negedge clk);
            cyc++;
            ch_valid = 4'b0000;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[k] || out_last !== (k == n - 1))
                $display("FAIL bp_beat%0d stall%0d: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                         k, stall, out_valid, out_data, out_last, exp_q[k], (k == n - 1));
            else passes++;
            if (k == stall_at && stall < 3) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = 1'b1;
                k++;
            end
        end
        checks++;
        if (k != n) $display("FAIL bp_timeout: beats seen=%0d want %0d", k, n);
        else passes++;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL bp_idle: valid=%b busy=%b want 0 0", out_valid, busy);
        else passes++;
    endtask

    task automatic test_fairness();
        int g, n;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pkts = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        for (int c = 0; c < 4; c++) ch_data[c*16 +: 16] = pkts[c];
        ch_valid = 4'b1111;
        out_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            g = p % 4;
            load_expect(g, pkts[g]);
            n = exp_q.size();
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_q[k] || out_last !== (k == n - 1) ||
                    ch_capture !== ((k == 0) ? (4'b0001 << g) : 4'b0000))
                    $display("FAIL fair_p%0d_beat%0d: valid=%b data=%h last=%b cap=%b want valid=1 data=%h last=%b cap=%b",
                             p, k, out_valid, out_data, out_last, ch_capture, exp_q[k], (k == n - 1),
                             ((k == 0) ? (4'b0001 << g) : 4'b0000));
                else passes++;
            end
            @(negedge clk);
            if (p == 5) ch_valid = 4'b0000;
            checks++;
            if (out_valid !== 1'b0 || ch_capture !== 4'h0)
                $display("FAIL fair_gap%0d: valid=%b cap=%b want valid=0 cap=0000", p, out_valid, ch_capture);
            else passes++;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL fair_end: valid=%b want 0", out_valid);
        else passes++;
    endtask

    task automatic test_wrap_skip();
        logic [3:0] req [3];
        int         want [3];
        int         n;
        req  = '{4'b0100, 4'b0010, 4'b0101};
        want = '{2, 1, 2};
        for (int s = 0; s < 3; s++) begin
            load_expect(want[s], pkts[want[s]]);
            n = exp_q.size();
            @(negedge clk);
            ch_valid = req[s];
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                ch_valid = 4'b0000;
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_q[k] || out_last !== (k == n - 1) ||
                    ch_capture !== ((k == 0) ? (4'b0001 << want[s]) : 4'b0000))
                    $display("FAIL wrap_s%0d_beat%0d: valid=%b data=%h last=%b cap=%b want valid=1 data=%h last=%b cap=%b",
                             s, k, out_valid, out_data, out_last, ch_capture, exp_q[k], (k == n - 1),
                             ((k == 0) ? (4'b0001 << want[s]) : 4'b0000));
                else passes++;
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) $display("FAIL wrap_gap%0d: valid=%b want 0", s, out_valid);
            else passes++;
        end
    endtask

    task automatic test_header_and_reset();
        int n;
        load_expect(3, 16'h1234);
        n = exp_q.size();
        @(negedge clk);
        ch_data[3*16 +: 16] = 16'h1234;
        ch_data[0 +: 16]    = 16'hBEEF;
        ch_valid = 4'b1000;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ch_valid = 4'b0000;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[k] || out_last !== (k == n - 1))
                $display("FAIL hdr_beat%0d: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                         k, out_valid, out_data, out_last, exp_q[k], (k == n - 1));
            else passes++;
        end
        load_expect(0, 16'hBEEF);
        @(negedge clk);
        ch_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ch_valid = 4'b0000;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[k])
                $display("FAIL midrst_beat%0d: valid=%b data=%h want valid=1 data=%h",
                         k, out_valid, out_data, exp_q[k]);
            else passes++;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_last !== 1'b0 || busy !== 1'b0 || ch_capture !== 4'h0)
            $display("FAIL midrst_async: valid=%b data=%h last=%b busy=%b cap=%b want all 0",
                     out_valid, out_data, out_last, busy, ch_capture);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || ch_capture !== 4'h0)
                $display("FAIL midrst_after%0d: valid=%b cap=%b want valid=0 cap=0000", c, out_valid, ch_capture);
            else passes++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        ch_data   = '0;
        ch_valid  = '0;
        out_ready = 1'b1;
        test_reset();
        test_single_packet();
        test_backpressure();
        test_fairness();
        test_wrap_skip();
        test_header_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
